// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame path (receiver and serializing transmitter).
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Level of an idle serial line.
    localparam logic IDLE_LEVEL = 1'b1;

    // Parity convention: 0 selects even parity over data+parity.
    localparam logic PARITY_ODD = 1'b0;

    // Error when the XOR over data and parity bit disagrees with the convention.
    function automatic logic parity_mismatch(input logic xor_all);
        return xor_all ^ PARITY_ODD;
    endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Parallel output bundle of the serial frame receiver.
interface serial_frame_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              parity_err_o;
    logic              frame_err_o;
    logic              busy_o;

    modport master (
        output data_o,
        output valid_o,
        output parity_err_o,
        output frame_err_o,
        output busy_o
    );

    modport slave (
        input data_o,
        input valid_o,
        input parity_err_o,
        input frame_err_o,
        input busy_o
    );
endinterface

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, reset to a chosen level.
module bit_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop -> parallel word.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    serial_frame_rx_if.master bus
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIDX_W = $clog2(DATA_W + 1);
    localparam int unsigned HALF   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0]  CNT_HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST    = BIDX_W'(DATA_W - 1);

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIDX_W-1:0]  bidx_q, bidx_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               par_q, par_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               busy_q, busy_d;
    logic               rx_s;
    logic               rx_prev_q;
    logic               fall;

    // Bring the line into the clock domain; idle reset level avoids a false start.
    bit_sync2 #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_s)
    );

    assign fall = (rx_s != IDLE_LEVEL) && (rx_prev_q == IDLE_LEVEL);

    // Next-state, counters, shift register and output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bidx_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d   = '0;
                    state_d = (rx_s == IDLE_LEVEL) ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = '0;
                    shreg_d = (shreg_q >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
                    if (bidx_q == BIDX_LAST) begin
                        bidx_d  = '0;
                        state_d = PARITY;
                    end else begin
                        bidx_d = bidx_q + BIDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = '0;
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                    perr_d  = parity_mismatch(^{shreg_q, par_q});
                    ferr_d  = ~rx_s;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bidx_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bidx_q    <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            rx_prev_q <= IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bidx_q    <= bidx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
            rx_prev_q <= rx_s;
        end
    end

    assign bus.data_o       = data_q;
    assign bus.valid_o      = valid_q;
    assign bus.parity_err_o = perr_q;
    assign bus.frame_err_o  = ferr_q;
    assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed and randomized frames checked against a timing/content reference model.
module tb_serial_frame_rx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CPB    = 4;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rx_i = 1'b1;
    int   cyc      = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  got_q[$];
    logic busy_hist[int];

    serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

    serial_frame_rx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rx_i (rx_i),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record busy level and every valid strobe, sampled mid-cycle.
    always @(negedge clk) begin
        ev_t e;
        busy_hist[cyc] = bus.busy_o;
        if (bus.valid_o === 1'b1) begin
            e.cyc  = cyc;
            e.data = bus.data_o;
            e.perr = bus.parity_err_o;
            e.ferr = bus.frame_err_o;
            got_q.push_back(e);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Drive one whole frame and predict its completion from the bit timing.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                              output int start);
        ev_t e;
        start = cyc;
        rx_i  = 1'b0;
        tick(CPB);
        for (int i = 0; i < int'(DATA_W); i++) begin
            rx_i = d[i];
            tick(CPB);
        end
        rx_i = pbit;
        tick(CPB);
        rx_i = stopb;
        tick(CPB);
        // drive cycle -> E0 (+1) -> E2 (+2) -> mid start (+CPB/2) -> stop bit (+(DATA_W+2)*CPB)
        e.cyc  = start + 3 + int'(CPB / 2) + int'((DATA_W + 2) * CPB);
        e.data = d;
        e.perr = 1'(($countones(d) + int'(pbit)) % 2);
        e.ferr = ~stopb;
        exp_q.push_back(e);
    endtask

    task automatic check_events(input string tag);
        int n;
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_cycle"}, 32'(got_q[i].cyc), 32'(exp_q[i].cyc));
            chk({tag, "_data"},  32'(got_q[i].data), 32'(exp_q[i].data));
            chk({tag, "_perr"},  32'(got_q[i].perr), 32'(exp_q[i].perr));
            chk({tag, "_ferr"},  32'(got_q[i].ferr), 32'(exp_q[i].ferr));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data"},  32'(bus.data_o), 32'h0);
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'h0);
        chk({tag, "_perr"},  32'(bus.parity_err_o), 32'h0);
        chk({tag, "_ferr"},  32'(bus.frame_err_o), 32'h0);
        chk({tag, "_busy"},  32'(bus.busy_o), 32'h0);
    endtask

    initial begin
        int         s;
        int         s2;
        int         gap;
        logic [7:0] d;
        logic       pbit;
        logic       stopb;
        logic       prev_stop_bad;

        // Reset state
        rst  = 1'b1;
        rx_i = 1'b1;
        tick(3);
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick(6);
        chk_outputs_zero("post_reset");

        // Clean frame with busy window
        send_frame(8'hA5, 1'b0, 1'b1, s);
        tick(4);
        check_events("clean");
        chk("clean_busy_e1",  32'(busy_hist[s + 2]),  32'h0);
        chk("clean_busy_e2",  32'(busy_hist[s + 3]),  32'h1);
        chk("clean_busy_e43", 32'(busy_hist[s + 44]), 32'h1);
        chk("clean_busy_e44", 32'(busy_hist[s + 45]), 32'h0);
        chk("clean_hold", 32'(bus.data_o), 32'hA5);

        // Parity error
        send_frame(8'hA5, 1'b1, 1'b1, s);
        tick(4);
        check_events("parity");

        // Frame error followed by a long break, then recovery
        send_frame(8'h3C, 1'b0, 1'b0, s);
        tick(100);
        check_events("break");
        chk("break_busy", 32'(bus.busy_o), 32'h0);
        rx_i = 1'b1;
        tick(8);
        send_frame(8'h01, 1'b1, 1'b1, s);
        tick(4);
        check_events("recover");

        // Glitch start: one low cycle
        s    = cyc;
        rx_i = 1'b0;
        tick(1);
        rx_i = 1'b1;
        tick(12);
        chk("glitch_busy_pre",  32'(busy_hist[s + 2]), 32'h0);
        chk("glitch_busy_a",    32'(busy_hist[s + 3]), 32'h1);
        chk("glitch_busy_b",    32'(busy_hist[s + 4]), 32'h1);
        chk("glitch_busy_post", 32'(busy_hist[s + 5]), 32'h0);
        check_events("glitch");

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b0, 1'b1, s);
        send_frame(8'hFF, 1'b0, 1'b1, s2);
        tick(4);
        check_events("b2b");

        // Reset during data bit 3 of 0x5A
        d    = 8'h5A;
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx_i = d[i];
            tick(CPB);
        end
        rx_i = d[3];
        tick(1);
        chk("midrst_busy_before", 32'(bus.busy_o), 32'h1);
        rst  = 1'b1;
        rx_i = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        tick(3);
        rst = 1'b0;
        tick(10);
        check_events("midrst_quiet");
        send_frame(8'h81, 1'b0, 1'b1, s);
        tick(4);
        check_events("after_rst");

        // Randomized frames with occasional parity/stop errors and random gaps
        prev_stop_bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            gap  = prev_stop_bad ? int'($urandom_range(2, 6)) : int'($urandom_range(0, 3));
            rx_i = 1'b1;
            tick(gap);
            d     = 8'($urandom);
            pbit  = 1'(($countones(d) % 2)) ^ (($urandom % 4) == 0);
            stopb = (($urandom % 4) != 0);
            send_frame(d, pbit, stopb, s);
            prev_stop_bad = ~stopb;
        end
        rx_i = 1'b1;
        tick(6);
        check_events("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Receives an asynchronous serial frame on a single line: idle-high, one start bit, `DATA_W` data bits LSB first, one even-parity bit, one stop bit. It presents the decoded word in parallel with a one-cycle valid strobe and per-frame error flags. It is the receiving end of the bit-serial shift path. A line driven one bit per `CLKS_PER_BIT` clocks by a serializing shifter is reassembled here into a parallel word. It sits between an external or cross-domain serial pin and the register-level logic that consumes bytes.

## Interface

- `DATA_W`, default 8: number of data bits per frame, ≥ 1.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Must be even and ≥ 2.

Ports:

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `rx_i`  in  1: serial line, asynchronous to `clk`, idle level 1.
- `data_o`  out  `DATA_W`: last received word; holds until the next frame completes.
- `valid_o`  out  1: one-cycle pulse when a frame completes, including frames with errors.
- `parity_err_o`  out  1: qualifies `valid_o`; received parity is not even over data+parity.
- `frame_err_o`  out  1: qualifies `valid_o`; sampled stop bit was 0.
- `busy_o`  out  1: high in every state except IDLE.

## Operation

- **Input synchronizer:** `rx_i` passes through 2 flops to give `rx_s`. Both flops reset to 1 (idle), so reset never produces a false start.
- **Start detection:** a start requires a falling edge: `rx_s`=0 while the previous `rx_s`=1, in IDLE. A line held low (break) never re-triggers.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a falling edge; the bit-cycle counter clears to 0.
  - START: counts `CLKS_PER_BIT/2` edges to mid-bit, then samples `rx_s`.
    - If the sample is 0, go to DATA with the counter cleared.
    - If the sample is 1 (glitch), return to IDLE with no output.
  - DATA: samples every `CLKS_PER_BIT` edges.
    - Shifts the bit into the shift register at position MSB, shifting right, so the first received bit ends at bit 0.
    - After `DATA_W` samples, go to PARITY.
  - PARITY: samples once after `CLKS_PER_BIT` edges, then goes to STOP.
  - STOP: samples once after `CLKS_PER_BIT` edges. On that edge:
    - `data_o` ← shift register;
    - `valid_o` ← 1;
    - `parity_err_o` ← XOR of data and parity bits;
    - `frame_err_o` ← ~stop sample;
    - then go to IDLE.
- **Strobe and flags:** `valid_o`, `parity_err_o` and `frame_err_o` are 0 on every cycle except the single cycle after the stop-sample edge.
- **Counter widths:**
  - Bit-cycle counter: `$clog2(CLKS_PER_BIT)` bits.
  - Bit index: `$clog2(DATA_W+1)` bits.
  - Both wrap only via explicit clear, never by overflow.
- **Reset, including mid-frame:** state IDLE, counters 0, shift register 0, synchronizer 1. All outputs 0: `data_o`=0, `valid_o`=0, `parity_err_o`=0, `frame_err_o`=0, `busy_o`=0.

## Timing

- Let E0 be the edge that first captures `rx_i`=0 into synchronizer stage 1.
- E1: `rx_s` becomes 0.
- E2: FSM leaves IDLE.
- Sample edges:
  - start at E2+`CLKS_PER_BIT/2`;
  - data bit k at E2+`CLKS_PER_BIT/2`+(k+1)·`CLKS_PER_BIT`;
  - parity at +(`DATA_W`+1)·`CLKS_PER_BIT`;
  - stop at +(`DATA_W`+2)·`CLKS_PER_BIT`.
- With defaults, the stop sample is at E44, and `valid_o` is high for the cycle E44–E45.
- **Back-to-back frames:** FSM is in IDLE at E45. A start bit beginning immediately after a stop bit (falling edge following a 1 stop sample) is accepted with no lost cycles.
- **Frame error without recovery:** after a frame error, a low line does not start a new frame until `rx_s` returns to 1.

## Structure

- **Shared package `serial_frame_pkg`:**
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - `IDLE_LEVEL`=1'b1;
  - the parity convention (even), shared with the serializing transmitter.
- **Sub-module `bit_sync2`:** 2-flop synchronizer with parameterized reset value, reusable elsewhere.
- **Remaining logic in the top level:** FSM, counters, shift register and output registers, all updated with nonblocking assignments in clocked processes.

## Test plan

- **Clean frame:** defaults; send 0xA5 with parity 0, stop 1 → `valid_o` one cycle at E44, `data_o`=0xA5, both error flags 0, `busy_o` high E2..E44.
- **Parity error:** send 0xA5 with parity 1 → `valid_o`=1, `data_o`=0xA5, `parity_err_o`=1, `frame_err_o`=0.
- **Frame error and break:**
  - Send 0x3C with stop bit 0, then hold the line low for 100 cycles → `valid_o`=1, `frame_err_o`=1, no further `valid_o`.
  - Line goes high, then 0x01 is sent → accepted normally.
- **Glitch start:** `rx_i` low for 1 cycle → `busy_o` high for 2 cycles, then back to IDLE; no `valid_o`.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap → two `valid_o` pulses exactly 44 cycles apart, data 0x00 then 0xFF, no errors.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0x5A for 3 cycles → all outputs 0 immediately; next full frame 0x81 is received correctly with no spurious `valid_o`.
